sifre_cozme: RTL and testbench
==============================

# sifre_cozme

Serial-to-parallel decryption stage that sits directly downstream of the serial encryption block. It collects a `BIT`-bit encrypted word arriving LSB-first, one bit per valid cycle, and reverses the rotate and XOR/XNOR transform using the same 8-entry key table. It then presents the recovered plaintext word on a ready/valid output. Frame gaps and output overruns are flagged, not silently absorbed.

## Interface
- `BIT`, 4, word width in bits; legal range 4..64.
- `saat` in 1: clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high reset.
- `bit_girisi` in 1: serial encrypted bit; bit i of the frame arrives on the i-th valid cycle.
- `gecerli_giris` in 1: `bit_girisi` valid this cycle.
- `mod` in 1: mode of the frame; 1 = XOR/rotate-left-2 encrypted, 0 = XNOR/rotate-right-2 encrypted.
- `secim` in 3: key index of the frame.
- `cikis_hazir` in 1: consumer accepts `veri_cikisi` this cycle.
- `veri_cikisi` out BIT: decrypted word; registered.
- `cikis_gecerli` out 1: `veri_cikisi` holds an unconsumed word.
- `hata` out 1: one-cycle pulse when a frame is aborted by a gap.
- `tasma` out 1: one-cycle pulse when a completed frame is dropped because the output is occupied.

## Operation
- Key table, 64-bit constants; the key used is `K = key[secim_l][BIT-1:0]`:
  - 0: BABA1453DEDE1071
  - 1: ACAB0909BACA0707
  - 2: ADAB0606DADA0505
  - 3: AAAA0000FFFF5555
  - 4: CAAA0101CAAA0101
  - 5: AACA0606AACA0606
  - 6: CAAA1717CAAA1717
  - 7: AAAA0000FFFF5555
- State machine, 2 states:
  - **BOS** (idle).
    - `gecerli_giris=1`: store bit into position 0, latch `mod` into `mod_l` and `secim` into `secim_l`, counter=1, go to ALIM.
  - **ALIM** (collecting).
    - `gecerli_giris=1` and counter<BIT-1: store bit at position counter, then counter+1.
    - `gecerli_giris=1` and counter==BIT-1: the received word R is complete, including the current bit. Decode and deliver R, counter=0, go to BOS.
    - `gecerli_giris=0`: pulse `hata`, discard partial word, counter=0, go to BOS.
  - For `BIT` in 4..64, completion in ALIM always follows at least one cycle in ALIM, so the BOS completion case never arises.
- Decode, where `{a,b}` is bit concatenation:
  - `mod_l=1`: `T = {R[1:0], R[BIT-1:2]}`, then plaintext = `T ^ K`.
  - `mod_l=0`: `T = {R[BIT-3:0], R[BIT-1:BIT-2]}`, then plaintext = `~(T ^ K)`.
- `mod`/`secim` are sampled only on the first bit of a frame. Changes mid-frame are ignored.
- Output register, at the completion edge:
  - If `cikis_gecerli=0`, or `cikis_hazir=1` in the same cycle: load plaintext and set `cikis_gecerli=1`.
  - Otherwise: keep the old word, drop the new one, pulse `tasma`.
- `cikis_gecerli` clears on any edge with `cikis_hazir=1` and no simultaneous completion. `cikis_hazir` while `cikis_gecerli=0` has no effect.
- Back-to-back frames are legal: valid in the cycle right after completion starts a new frame from BOS.

## Timing
- Reset values: `veri_cikisi=0`, `cikis_gecerli=0`, `hata=0`, `tasma=0`, state BOS, counter=0.
- Reset takes priority over all activity. Reset mid-frame discards the partial word and emits no `hata`.
- Latency: if the last bit is valid in cycle n, `cikis_gecerli` and the word are visible in cycle n+1.
- `hata` is high in the cycle after the first invalid cycle inside ALIM.
- `tasma` is high in the cycle after the dropping completion.
- `hata` and `tasma` are each exactly one cycle wide.

## Test plan
- BIT=4, `mod=1`, `secim=0` (K=0x1), serial bits 0,1,1,1 (R=0xE) -> `veri_cikisi=0xA`, `cikis_gecerli` high the cycle after bit 3; stays high until `cikis_hazir`.
- BIT=4, `mod=0`, `secim=3` (K=0x5), bits 1,1,0,0 (R=0x3) -> `veri_cikisi=0x6`.
- Gap after 2 bits (`gecerli_giris` low one cycle), then a full frame as in case 1 -> one `hata` pulse, no output for the partial frame, then `veri_cikisi=0xA`.
- Two back-to-back frames as in case 1 with `cikis_hazir=0` -> first word 0xA held, one `tasma` pulse; repeat with `cikis_hazir=1` at the second completion -> second word loaded, `cikis_gecerli` stays 1, no `tasma`.
- `reset` asserted after 2 bits of a frame -> all outputs 0, no `hata`; the next full frame decodes correctly.
- BIT=64 loopback with the encryption block: all 8 `secim` values, both modes, random data -> plaintext equals encryptor input every frame.

Source files
------------

// File: rtl/sifre_cozme.sv
// Serial-to-parallel decryption: collects a BIT-bit word LSB-first and undoes the rotate + XOR/XNOR transform.
// Latency: plaintext and cikis_gecerli visible one cycle after the last valid bit.
// Backpressure: one-word output register; a completed frame arriving while it is occupied is dropped and flagged on tasma.
module sifre_cozme #(
  parameter int BIT = 4
) (
  input  logic           saat,
  input  logic           reset,
  input  logic           bit_girisi,
  input  logic           gecerli_giris,
  input  logic           mod,
  input  logic [2:0]     secim,
  input  logic           cikis_hazir,
  output logic [BIT-1:0] veri_cikisi,
  output logic           cikis_gecerli,
  output logic           hata,
  output logic           tasma
);

  localparam int CW = $clog2(BIT);

  // Same key table as the encryptor; only the low BIT bits of an entry are used.
  localparam logic [63:0] ANAHTAR [8] = '{
    64'hBABA1453DEDE1071,
    64'hACAB0909BACA0707,
    64'hADAB0606DADA0505,
    64'hAAAA0000FFFF5555,
    64'hCAAA0101CAAA0101,
    64'hAACA0606AACA0606,
    64'hCAAA1717CAAA1717,
    64'hAAAA0000FFFF5555
  };

  typedef enum logic {BOS, ALIM} state_t;

  state_t         state, state_next;
  logic [CW-1:0]  sayac;
  logic [BIT-1:0] alinan;
  logic           mod_l;
  logic [2:0]     secim_l;
  logic           tamam;
  logic [BIT-1:0] kelime;
  logic [BIT-1:0] anahtar;
  logic [BIT-1:0] duz;

  // State register.
  always_ff @(posedge saat) begin
    if (reset) state <= BOS;
    else       state <= state_next;
  end

  // Next state; tamam marks the edge on which the last bit of a frame is taken.
  always_comb begin
    state_next = state;
    tamam      = 1'b0;
    case (state)
      BOS: begin
        if (gecerli_giris) state_next = ALIM;
      end
      ALIM: begin
        if (!gecerli_giris) begin
          state_next = BOS;
        end else if (sayac == CW'(BIT - 1)) begin
          tamam      = 1'b1;
          state_next = BOS;
        end
      end
      default: state_next = BOS;
    endcase
  end

  // Bit collection plus per-frame capture of mode and key index from the first bit.
  always_ff @(posedge saat) begin
    if (reset) begin
      sayac   <= '0;
      alinan  <= '0;
      mod_l   <= 1'b0;
      secim_l <= 3'd0;
    end else begin
      case (state)
        BOS: begin
          if (gecerli_giris) begin
            alinan[0] <= bit_girisi;
            mod_l     <= mod;
            secim_l   <= secim;
            sayac     <= CW'(1);
          end
        end
        ALIM: begin
          if (gecerli_giris && !tamam) begin
            alinan[sayac] <= bit_girisi;
            sayac         <= sayac + 1'b1;
          end else begin
            sayac <= '0;
          end
        end
        default: sayac <= '0;
      endcase
    end
  end

  // Inverse transform; the current bit completes the word so decode sees it combinationally.
  always_comb begin
    kelime  = {bit_girisi, alinan[BIT-2:0]};
    anahtar = ANAHTAR[secim_l][BIT-1:0];
    if (mod_l) duz = {kelime[1:0], kelime[BIT-1:2]} ^ anahtar;
    else       duz = ~({kelime[BIT-3:0], kelime[BIT-1:BIT-2]} ^ anahtar);
  end

  // Output register with drop-on-occupied, plus the one-cycle gap and overrun pulses.
  always_ff @(posedge saat) begin
    if (reset) begin
      veri_cikisi   <= '0;
      cikis_gecerli <= 1'b0;
      hata          <= 1'b0;
      tasma         <= 1'b0;
    end else begin
      hata  <= (state == ALIM) && !gecerli_giris;
      tasma <= tamam && cikis_gecerli && !cikis_hazir;
      if (tamam && (!cikis_gecerli || cikis_hazir)) begin
        veri_cikisi   <= duz;
        cikis_gecerli <= 1'b1;
      end else if (cikis_hazir) begin
        cikis_gecerli <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sifre_cozme.sv
// Bench for sifre_cozme: directed BIT=4 scenarios and a BIT=64 loopback against a behavioural encryptor.
// Expected words are queued when a frame is driven and popped when the DUT presents output.
module tb_sifre_cozme;

  logic saat = 1'b0;
  logic reset;

  logic       b4, v4, m4, h4;
  logic [2:0] s4;
  logic [3:0] d4;
  logic       cv4, he4, ta4;

  logic        b64, v64, m64, h64;
  logic [2:0]  s64;
  logic [63:0] d64;
  logic        cv64, he64, ta64;

  int checks = 0;
  int errors = 0;
  int hata_seen4 = 0, tasma_seen4 = 0, tasma_seen64 = 0, hata_seen64 = 0;

  logic [3:0]  exp4[$];
  logic [63:0] exp64[$];

  always #5 saat = ~saat;

  sifre_cozme #(.BIT(4)) dut4 (
    .saat(saat), .reset(reset), .bit_girisi(b4), .gecerli_giris(v4), .mod(m4),
    .secim(s4), .cikis_hazir(h4), .veri_cikisi(d4), .cikis_gecerli(cv4),
    .hata(he4), .tasma(ta4)
  );

  sifre_cozme #(.BIT(64)) dut64 (
    .saat(saat), .reset(reset), .bit_girisi(b64), .gecerli_giris(v64), .mod(m64),
    .secim(s64), .cikis_hazir(h64), .veri_cikisi(d64), .cikis_gecerli(cv64),
    .hata(he64), .tasma(ta64)
  );

  // Pulse counters, sampled shortly after each rising edge.
  always @(posedge saat) begin
    #2;
    if (he4)  hata_seen4++;
    if (ta4)  tasma_seen4++;
    if (he64) hata_seen64++;
    if (ta64) tasma_seen64++;
  end

  function automatic logic [63:0] key_of(input logic [2:0] s);
    case (s)
      3'd0: key_of = 64'hBABA1453DEDE1071;
      3'd1: key_of = 64'hACAB0909BACA0707;
      3'd2: key_of = 64'hADAB0606DADA0505;
      3'd3: key_of = 64'hAAAA0000FFFF5555;
      3'd4: key_of = 64'hCAAA0101CAAA0101;
      3'd5: key_of = 64'hAACA0606AACA0606;
      3'd6: key_of = 64'hCAAA1717CAAA1717;
      default: key_of = 64'hAAAA0000FFFF5555;
    endcase
  endfunction

  // Behavioural 64-bit encryptor: XOR then rotate-left-2, or XNOR then rotate-right-2.
  function automatic logic [63:0] sifrele(input logic [63:0] p, input logic m, input logic [2:0] s);
    logic [63:0] x;
    x = p ^ key_of(s);
    if (m) sifrele = {x[61:0], x[63:62]};
    else begin
      x = ~x;
      sifrele = {x[1:0], x[63:2]};
    end
  endfunction

  // Drive a full 4-bit frame; cikis_hazir is raised only with the last bit when hz is set.
  task automatic send4(input logic [3:0] r, input logic m, input logic [2:0] s, input logic hz);
    for (int i = 0; i < 4; i++) begin
      b4 = r[i]; v4 = 1'b1; m4 = m; s4 = s; h4 = (i == 3) ? hz : 1'b0;
      @(negedge saat);
    end
  endtask

  task automatic idle4(input int n);
    b4 = 1'b0; v4 = 1'b0; h4 = 1'b0;
    repeat (n) @(negedge saat);
  endtask

  task automatic consume4();
    v4 = 1'b0; h4 = 1'b1;
    @(negedge saat);
    h4 = 1'b0;
    checks++;
    if (cv4 !== 1'b0) begin errors++; $display("FAIL consume4_clear: cikis_gecerli=%b want 0", cv4); end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    b4 = 0; v4 = 0; m4 = 0; s4 = 0; h4 = 0;
    b64 = 0; v64 = 0; m64 = 0; s64 = 0; h64 = 0;
    repeat (3) @(negedge saat);
    checks++;
    if ({d4, cv4, he4, ta4} !== 7'd0) begin
      errors++; $display("FAIL reset4: veri=%h vld=%b hata=%b tasma=%b want all 0", d4, cv4, he4, ta4);
    end
    checks++;
    if ({d64, cv64, he64, ta64} !== 67'd0) begin
      errors++; $display("FAIL reset64: veri=%h vld=%b hata=%b tasma=%b want all 0", d64, cv64, he64, ta64);
    end
    reset = 1'b0;
    @(negedge saat);
  endtask

  task automatic test_xor();
    logic [3:0] e;
    exp4.push_back(4'hA);
    send4(4'hE, 1'b1, 3'd0, 1'b0);
    v4 = 1'b0;
    checks++;
    if (cv4 !== 1'b1) begin errors++; $display("FAIL xor_latency: cikis_gecerli=%b want 1", cv4); end
    else begin
      e = exp4.pop_front();
      checks++;
      if (d4 !== e) begin errors++; $display("FAIL xor_data: veri=%h want %h", d4, e); end
    end
    idle4(3);
    checks++;
    if (cv4 !== 1'b1 || d4 !== 4'hA) begin
      errors++; $display("FAIL xor_hold: vld=%b veri=%h want 1/a", cv4, d4);
    end
    consume4();
  endtask

  task automatic test_xnor();
    logic [3:0] e;
    exp4.push_back(4'h6);
    send4(4'h3, 1'b0, 3'd3, 1'b0);
    v4 = 1'b0;
    checks++;
    if (cv4 !== 1'b1) begin errors++; $display("FAIL xnor_valid: cikis_gecerli=%b want 1", cv4); end
    else begin
      e = exp4.pop_front();
      checks++;
      if (d4 !== e) begin errors++; $display("FAIL xnor_data: veri=%h want %h", d4, e); end
    end
    consume4();
  endtask

  task automatic test_gap();
    int h0;
    logic [3:0] e;
    h0 = hata_seen4;
    b4 = 1'b0; v4 = 1'b1; m4 = 1'b1; s4 = 3'd0; @(negedge saat);
    b4 = 1'b1; @(negedge saat);
    v4 = 1'b0; @(negedge saat);
    checks++;
    if (he4 !== 1'b1) begin errors++; $display("FAIL gap_hata: hata=%b want 1", he4); end
    checks++;
    if (cv4 !== 1'b0) begin errors++; $display("FAIL gap_no_output: vld=%b want 0", cv4); end
    @(negedge saat);
    checks++;
    if (he4 !== 1'b0) begin errors++; $display("FAIL gap_pulse_width: hata=%b want 0", he4); end
    exp4.push_back(4'hA);
    send4(4'hE, 1'b1, 3'd0, 1'b0);
    v4 = 1'b0;
    checks++;
    if (cv4 !== 1'b1) begin errors++; $display("FAIL gap_next_valid: vld=%b want 1", cv4); end
    else begin
      e = exp4.pop_front();
      checks++;
      if (d4 !== e) begin errors++; $display("FAIL gap_next_data: veri=%h want %h", d4, e); end
    end
    idle4(1);
    checks++;
    if (hata_seen4 - h0 !== 1) begin errors++; $display("FAIL gap_hata_count: %0d pulses want 1", hata_seen4 - h0); end
    consume4();
  endtask

  task automatic test_back_to_back();
    int t0;
    logic [3:0] e;
    t0 = tasma_seen4;
    exp4.push_back(4'hA);
    send4(4'hE, 1'b1, 3'd0, 1'b0);
    checks++;
    if (cv4 !== 1'b1) begin errors++; $display("FAIL b2b_first_valid: vld=%b want 1", cv4); end
    else begin
      e = exp4.pop_front();
      checks++;
      if (d4 !== e) begin errors++; $display("FAIL b2b_first_data: veri=%h want %h", d4, e); end
    end
    // Second frame (would decode to 6) completes with the output still full: dropped.
    send4(4'h3, 1'b0, 3'd3, 1'b0);
    checks++;
    if (ta4 !== 1'b1) begin errors++; $display("FAIL b2b_tasma: tasma=%b want 1", ta4); end
    checks++;
    if (cv4 !== 1'b1 || d4 !== 4'hA) begin errors++; $display("FAIL b2b_held: vld=%b veri=%h want 1/a", cv4, d4); end
    // Third frame completes together with cikis_hazir: loaded, valid stays high.
    exp4.push_back(4'h6);
    send4(4'h3, 1'b0, 3'd3, 1'b1);
    v4 = 1'b0; h4 = 1'b0;
    checks++;
    if (cv4 !== 1'b1 || ta4 !== 1'b0) begin errors++; $display("FAIL b2b_swap: vld=%b tasma=%b want 1/0", cv4, ta4); end
    else begin
      e = exp4.pop_front();
      checks++;
      if (d4 !== e) begin errors++; $display("FAIL b2b_swap_data: veri=%h want %h", d4, e); end
    end
    idle4(1);
    checks++;
    if (tasma_seen4 - t0 !== 1) begin errors++; $display("FAIL b2b_tasma_count: %0d pulses want 1", tasma_seen4 - t0); end
    consume4();
  endtask

  task automatic test_reset_mid();
    int h0;
    logic [3:0] e;
    send4(4'hE, 1'b1, 3'd0, 1'b0);
    b4 = 1'b1; v4 = 1'b1; @(negedge saat);
    b4 = 1'b0; @(negedge saat);
    h0 = hata_seen4;
    reset = 1'b1; v4 = 1'b0; @(negedge saat);
    reset = 1'b0;
    checks++;
    if ({d4, cv4, he4, ta4} !== 7'd0) begin
      errors++; $display("FAIL reset_mid: veri=%h vld=%b hata=%b tasma=%b want all 0", d4, cv4, he4, ta4);
    end
    @(negedge saat);
    checks++;
    if (hata_seen4 !== h0) begin errors++; $display("FAIL reset_mid_hata: %0d pulses want 0", hata_seen4 - h0); end
    exp4.push_back(4'hA);
    send4(4'hE, 1'b1, 3'd0, 1'b0);
    v4 = 1'b0;
    checks++;
    if (cv4 !== 1'b1) begin errors++; $display("FAIL reset_mid_next_valid: vld=%b want 1", cv4); end
    else begin
      e = exp4.pop_front();
      checks++;
      if (d4 !== e) begin errors++; $display("FAIL reset_mid_next_data: veri=%h want %h", d4, e); end
    end
    consume4();
  endtask

  // BIT=64 loopback: every key, both modes, random plaintext, back-to-back frames.
  task automatic test_loopback64();
    logic [63:0] p, r, e;
    int t0;
    t0 = tasma_seen64 + hata_seen64;
    for (int s = 0; s < 8; s++) begin
      for (int m = 0; m < 2; m++) begin
        for (int k = 0; k < 2; k++) begin
          p = {$urandom, $urandom};
          r = sifrele(p, m[0], s[2:0]);
          exp64.push_back(p);
          for (int i = 0; i < 64; i++) begin
            b64 = r[i]; v64 = 1'b1; h64 = (i == 63);
            // Mode/key change after the first bit must be ignored.
            m64 = (i == 0) ? m[0] : ~m[0];
            s64 = (i == 0) ? s[2:0] : s[2:0] + 3'd3;
            @(negedge saat);
          end
          checks++;
          if (cv64 !== 1'b1) begin errors++; $display("FAIL loop_valid s=%0d m=%0d: vld=%b want 1", s, m, cv64); end
          else begin
            e = exp64.pop_front();
            checks++;
            if (d64 !== e) begin errors++; $display("FAIL loop_data s=%0d m=%0d: veri=%h want %h", s, m, d64, e); end
          end
        end
      end
    end
    v64 = 1'b0; h64 = 1'b1; @(negedge saat);
    h64 = 1'b0; @(negedge saat);
    checks++;
    if (cv64 !== 1'b0) begin errors++; $display("FAIL loop_drain: vld=%b want 0", cv64); end
    checks++;
    if (tasma_seen64 + hata_seen64 !== t0) begin errors++; $display("FAIL loop_flags: unexpected hata/tasma pulses"); end
  endtask

  initial begin
    test_reset();
    test_xor();
    test_xnor();
    test_gap();
    test_back_to_back();
    test_reset_mid();
    test_loopback64();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
